// File: rtl/des_pkg.sv
// DES round-engine shared package: S-boxes, E/P index tables, widths, FSM states.
// Table entries use DES 1-based bit numbering (bit 1 = MSB).
package des_pkg;

    localparam int DES_BLOCK_W  = 64;
    localparam int DES_HALF_W   = 32;
    localparam int DES_SUBKEY_W = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Indexed as [box][row*16 + column]
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

endpackage

// File: rtl/des_f_function.sv
// DES Feistel function f(R,K): E-expansion, key mix, S1..S8, P permutation.
// Purely combinational; vector bit 31/47 is DES bit 1.
module des_f_function
    import des_pkg::*;
(
    input  logic [DES_HALF_W-1:0]   i_r,
    input  logic [DES_SUBKEY_W-1:0] i_k,
    output logic [DES_HALF_W-1:0]   o_f
);

    logic [DES_SUBKEY_W-1:0] w_e;
    logic [DES_SUBKEY_W-1:0] w_x;
    logic [DES_HALF_W-1:0]   w_s;

    for (genvar i = 0; i < DES_SUBKEY_W; i++) begin : g_e
        assign w_e[DES_SUBKEY_W-1-i] = i_r[DES_HALF_W-E_TAB[i]];
    end

    assign w_x = w_e ^ i_k;

    // Row = outer bits of each 6-bit group, column = inner four
    for (genvar j = 0; j < 8; j++) begin : g_s
        logic [5:0] w_b;
        assign w_b = w_x[47-6*j -: 6];
        assign w_s[31-4*j -: 4] = SBOX[j][{w_b[5], w_b[0], w_b[4:1]}];
    end

    for (genvar i = 0; i < DES_HALF_W; i++) begin : g_p
        assign o_f[DES_HALF_W-1-i] = w_s[DES_HALF_W-P_TAB[i]];
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES round engine: one Feistel round per clock, emits R16||L16.
// Optional `DES_ROUND_ABORT_EN adds an abort input that drops the current block.
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int RIDX_W     = 4
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DES_BLOCK_W-1:0]  block_in,
    input  logic                    decrypt,
`ifdef DES_ROUND_ABORT_EN
    input  logic                    abort,
`endif
    output logic [RIDX_W-1:0]       round_idx,
    input  logic [DES_SUBKEY_W-1:0] subkey_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DES_BLOCK_W-1:0]  block_out
);

    localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NUM_ROUNDS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DES_HALF_W-1:0] r_l;
    logic [DES_HALF_W-1:0] r_r;
    logic [DES_HALF_W-1:0] w_f;
    logic [RIDX_W-1:0]     r_cnt;
    logic                  r_dec;
    logic                  w_abort;
    logic                  w_load;
    logic                  w_round;
    logic                  w_clear;

`ifdef DES_ROUND_ABORT_EN
    assign w_abort = abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    des_f_function u_f (
        .i_r (r_r),
        .i_k (subkey_in),
        .o_f (w_f)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_round     = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_round = 1'b1;
                if (r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort overrides both handshakes
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_load      = 1'b0;
            w_round     = 1'b0;
            w_clear     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_l     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_l   <= '0;
                r_r   <= '0;
                r_cnt <= '0;
            end else if (w_load) begin
                r_l   <= block_in[DES_BLOCK_W-1:DES_HALF_W];
                r_r   <= block_in[DES_HALF_W-1:0];
                r_dec <= decrypt;
                r_cnt <= '0;
            end else if (w_round) begin
                r_l <= r_r;
                r_r <= r_l ^ w_f;
                if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign round_idx = (r_state != RUN) ? '0 :
                       r_dec ? (LAST - r_cnt) : r_cnt;
    // Final swap: straight from the half registers
    assign block_out = {r_r, r_l};

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: known-answer table, round-trip and
// complementation properties on random keys, backpressure, reset and abort cases.
module tb_des_round_engine;

    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_P = 64'hCC00CCFFF0AAF0AA;
    localparam logic [63:0] KAT_C = 64'h0A4CD99543423234;

    localparam int PC1 [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
        10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4
    };
    localparam int PC2 [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,
        23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,
        44,49,39,56,34,53,46,42,50,36,29,32
    };
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct {
        string       nm;
        logic [63:0] key;
        logic [63:0] blk;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] block_in;
    logic        decrypt;
    logic [3:0]  round_idx;
    logic [47:0] subkey_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] block_out;
    logic        abort;

    logic        r1_valid;
    logic        r1_ready;
    logic [3:0]  r1_idx;
    logic [47:0] r1_key;
    logic        r1_ov;
    logic [63:0] r1_out;

    logic [47:0] ks [16];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    assign subkey_in = ks[round_idx];
    assign r1_key    = ks[r1_idx];

    des_round_engine u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .decrypt   (decrypt),
`ifdef DES_ROUND_ABORT_EN
        .abort     (abort),
`endif
        .round_idx (round_idx),
        .subkey_in (subkey_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .block_out (block_out)
    );

    des_round_engine #(.NUM_ROUNDS(1), .RIDX_W(4)) u_r1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r1_valid),
        .in_ready  (r1_ready),
        .block_in  (block_in),
        .decrypt   (1'b0),
`ifdef DES_ROUND_ABORT_EN
        .abort     (1'b0),
`endif
        .round_idx (r1_idx),
        .subkey_in (r1_key),
        .out_valid (r1_ov),
        .out_ready (1'b1),
        .block_out (r1_out)
    );

    task automatic chk64(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    // Standard DES key schedule: PC-1, per-round left rotates, PC-2
    task automatic build_ks(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-PC2[i]];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full block; decrypt/in_valid/block_in are scrambled while RUN
    task automatic run_block(input logic [63:0] blk, input logic dec,
                             output logic [63:0] res);
        int          w;
        logic        idx_ok, lat_ok;
        logic [3:0]  ei;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        chk1("accept_ready", in_ready, 1'b1);
        block_in = blk;
        decrypt  = dec;
        in_valid = 1'b1;
        tick();
        idx_ok = 1'b1;
        lat_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ei = dec ? 4'(15 - i) : 4'(i);
            if (round_idx !== ei) idx_ok = 1'b0;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) lat_ok = 1'b0;
            decrypt  = 1'($urandom);
            in_valid = 1'($urandom);
            block_in = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || round_idx !== 4'd0) lat_ok = 1'b0;
        res = block_out;
        if (out_ready) begin
            tick();
            if (in_ready !== 1'b1 || out_valid !== 1'b0) lat_ok = 1'b0;
        end
        chk1("round_idx_seq", idx_ok, 1'b1);
        chk1("latency", lat_ok, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [2];
        logic [63:0] res, c, p, c2, key, blk;
        logic        ok;

        vecs[0] = '{nm: "kat_enc", key: KEY, blk: KAT_P, dec: 1'b0, exp: KAT_C};
        vecs[1] = '{nm: "kat_dec", key: KEY, blk: KAT_C, dec: 1'b1, exp: KAT_P};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        block_in  = '0;
        decrypt   = 1'b0;
        out_ready = 1'b1;
        abort     = 1'b0;
        r1_valid  = 1'b0;
        build_ks(KEY);
        #12;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk64("rst_block_out", block_out, 64'd0);
        chk64("rst_round_idx", 64'(round_idx), 64'd0);

        tick();
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
                block_out !== 64'd0) ok = 1'b0;
        end
        chk1("idle_stable", ok, 1'b1);

        // Single-round instance exposes L1/R1
        block_in = KAT_P;
        r1_valid = 1'b1;
        tick();
        r1_valid = 1'b0;
        chk1("r1_busy", r1_ready, 1'b0);
        tick();
        chk1("r1_valid", r1_ov, 1'b1);
        chk64("r1_block", r1_out, 64'hEF4A6544F0AAF0AA);
        tick();

        for (int v = 0; v < 2; v++) begin
            build_ks(vecs[v].key);
            run_block(vecs[v].blk, vecs[v].dec, res);
            chk64(vecs[v].nm, res, vecs[v].exp);
        end

        for (int it = 0; it < 6; it++) begin
            key = {$urandom, $urandom};
            blk = {$urandom, $urandom};
            build_ks(key);
            run_block(blk, 1'b0, c);
            run_block(c, 1'b1, p);
            chk64("roundtrip", p, blk);
            if (it < 3) begin
                build_ks(~key);
                run_block(~blk, 1'b0, c2);
                chk64("complement", c2, ~c);
            end
        end

        // Backpressure with a pending second block
        build_ks(KEY);
        out_ready = 1'b0;
        run_block(KAT_P, 1'b0, res);
        chk64("bp_first", res, KAT_C);
        in_valid = 1'b1;
        block_in = KAT_C;
        decrypt  = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (block_out !== KAT_C || out_valid !== 1'b1 ||
                in_ready !== 1'b0) ok = 1'b0;
        end
        chk1("bp_hold", ok, 1'b1);
        out_ready = 1'b1;
        tick();
        chk1("bp_release_ready", in_ready, 1'b1);
        chk1("bp_release_ov", out_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        chk1("bp_second_accept", in_ready, 1'b0);
        repeat (16) tick();
        chk1("bp_second_valid", out_valid, 1'b1);
        chk64("bp_second_block", block_out, KAT_P);
        tick();

        // Reset in the middle of RUN
        block_in = KAT_P;
        decrypt  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk64("mid_rst_block_out", block_out, 64'd0);
        chk64("mid_rst_round_idx", 64'(round_idx), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk1("mid_rst_no_valid", ok, 1'b1);
        run_block(KAT_P, 1'b0, res);
        chk64("post_rst_enc", res, KAT_C);

`ifdef DES_ROUND_ABORT_EN
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_idle_ready", in_ready, 1'b1);
        chk64("abort_idle_block", block_out, KAT_C);

        block_in = KAT_P;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_run_ready", in_ready, 1'b1);
        chk64("abort_run_block", block_out, 64'd0);
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk1("abort_run_no_valid", ok, 1'b1);

        out_ready = 1'b0;
        run_block(KAT_P, 1'b0, res);
        chk64("abort_done_pre", res, KAT_C);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_done_ov", out_valid, 1'b0);
        chk1("abort_done_ready", in_ready, 1'b1);
        chk64("abort_done_block", block_out, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
